// File: rtl/arm_decode_stage.sv
// ARM decode stage: DEPTH-entry instruction queue feeding a registered decode bundle.
// Define DECODE_MULTIPLY_EN to decode MUL/MLA; otherwise that encoding is flagged undefined.
module arm_decode_stage #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [ADDR_WIDTH-1:0]        in_pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [3:0]                   cond,
  output logic [3:0]                   opcode,
  output logic                         set_flags,
  output logic [3:0]                   rd,
  output logic [3:0]                   rn,
  output logic [3:0]                   rm,
  output logic [3:0]                   rs,
  output logic [1:0]                   shift,
  output logic [4:0]                   shift_amount,
  output logic                         use_rs,
  output logic                         use_imm32,
  output logic                         use_register,
  output logic [3:0]                   rotate_imm,
  output logic [7:0]                   imm8,
  output logic                         access_memory,
  output logic                         is_load,
  output logic                         is_unsigned_byte,
  output logic                         is_not_postindex,
  output logic                         is_added_offset,
  output logic                         is_write_back,
  output logic                         mem_write,
  output logic [11:0]                  offset_12,
  output logic                         is_branch,
  output logic                         branch_with_link,
  output logic [ADDR_WIDTH-1:0]        branch_target,
  output logic                         is_multiply,
  output logic                         accumulate,
  output logic                         undefined
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int EXT_W = (ADDR_WIDTH > 26) ? ADDR_WIDTH : 26;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [3:0]            cond;
    logic [3:0]            opcode;
    logic                  set_flags;
    logic [3:0]            rd;
    logic [3:0]            rn;
    logic [3:0]            rm;
    logic [3:0]            rs;
    logic [1:0]            shift;
    logic [4:0]            shift_amount;
    logic                  use_rs;
    logic                  use_imm32;
    logic                  use_register;
    logic [3:0]            rotate_imm;
    logic [7:0]            imm8;
    logic                  access_memory;
    logic                  is_load;
    logic                  is_unsigned_byte;
    logic                  is_not_postindex;
    logic                  is_added_offset;
    logic                  is_write_back;
    logic                  mem_write;
    logic [11:0]           offset_12;
    logic                  is_branch;
    logic                  branch_with_link;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  is_multiply;
    logic                  accumulate;
    logic                  undefined;
  } bundle_t;

  function automatic logic [ADDR_WIDTH-1:0] branch_dest(input logic [ADDR_WIDTH-1:0] pc,
                                                        input logic [23:0] imm24);
    logic signed [25:0]      off26;
    logic signed [EXT_W-1:0] off_ext;
    off26   = signed'({imm24, 2'b00});
    off_ext = EXT_W'(off26);
    return pc + ADDR_WIDTH'(8) + off_ext[ADDR_WIDTH-1:0];
  endfunction

  function automatic bundle_t decode(input logic [31:0] ins, input logic [ADDR_WIDTH-1:0] pc);
    bundle_t b;
    logic    undef;
    b     = '0;
    undef = 1'b0;
    if (ins[31:28] == 4'hF) begin
      undef = 1'b1;
`ifdef DECODE_MULTIPLY_EN
    end else if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001) begin
      b.is_multiply = 1'b1;
      b.accumulate  = ins[21];
      b.set_flags   = ins[20];
      b.rd          = ins[19:16];
      b.rn          = ins[15:12];
      b.rs          = ins[11:8];
      b.rm          = ins[3:0];
`else
    end else if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001) begin
      undef = 1'b1;
`endif
    end else begin
      case (ins[27:25])
        3'b000: begin
          // bits 4 and 7 both set is the multiply/extra-load space, not a shifter operand
          if (ins[4] && ins[7]) begin
            undef = 1'b1;
          end else begin
            b.opcode       = ins[24:21];
            b.set_flags    = ins[20];
            b.rn           = ins[19:16];
            b.rd           = ins[15:12];
            b.shift        = ins[6:5];
            b.rm           = ins[3:0];
            b.use_register = 1'b1;
            if (ins[4]) begin
              b.use_rs = 1'b1;
              b.rs     = ins[11:8];
            end else begin
              b.shift_amount = ins[11:7];
            end
          end
        end
        3'b001: begin
          b.opcode     = ins[24:21];
          b.set_flags  = ins[20];
          b.rn         = ins[19:16];
          b.rd         = ins[15:12];
          b.use_imm32  = 1'b1;
          b.rotate_imm = ins[11:8];
          b.imm8       = ins[7:0];
        end
        3'b010, 3'b011: begin
          if (ins[25] && ins[4]) begin
            undef = 1'b1;
          end else begin
            b.access_memory    = 1'b1;
            b.is_not_postindex = ins[24];
            b.is_added_offset  = ins[23];
            b.is_unsigned_byte = ins[22];
            b.is_write_back    = ins[21];
            b.is_load          = ins[20];
            b.mem_write        = ~ins[20];
            b.rn               = ins[19:16];
            b.rd               = ins[15:12];
            if (ins[25]) begin
              b.use_register = 1'b1;
              b.rm           = ins[3:0];
              b.shift_amount = ins[11:7];
              b.shift        = ins[6:5];
            end else begin
              b.offset_12 = ins[11:0];
            end
          end
        end
        3'b101: begin
          b.is_branch        = 1'b1;
          b.branch_with_link = ins[24];
          b.branch_target    = branch_dest(pc, ins[23:0]);
        end
        default: undef = 1'b1;
      endcase
    end
    if (undef) begin
      b           = '0;
      b.undefined = 1'b1;
    end
    b.cond = ins[31:28];
    b.pc   = pc;
    return b;
  endfunction

  // Stage p0: instruction queue
  logic [31:0]           instr_q_p0 [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q_p0    [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_p0;
  logic [PTR_W-1:0]      rd_ptr_p0;
  logic [CNT_W-1:0]      count_p0;
  logic                  full_p0;
  logic                  empty_p0;
  logic                  push_p0;
  logic                  pop_p0;
  bundle_t               decoded_p0;

  logic                  vld_p1;
  bundle_t               bundle_p1;

  assign full_p0    = (count_p0 == CNT_W'(DEPTH));
  assign empty_p0   = (count_p0 == '0);
  assign in_ready   = ~full_p0;
  assign push_p0    = in_valid & ~full_p0 & ~flush & ~reset;
  assign pop_p0     = ~empty_p0 & (~vld_p1 | out_ready) & ~flush & ~reset;
  assign decoded_p0 = decode(instr_q_p0[rd_ptr_p0], pc_q_p0[rd_ptr_p0]);

  always_ff @(posedge clk) begin
    if (push_p0) begin
      instr_q_p0[wr_ptr_p0] <= in_instr;
      pc_q_p0[wr_ptr_p0]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (push_p0) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
      if (pop_p0)  rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count_p0 <= count_p0 + CNT_W'(1);
        2'b01:   count_p0 <= count_p0 - CNT_W'(1);
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Stage p1: registered decode bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (pop_p0) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= decoded_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign queue_count      = count_p0;
  assign out_valid        = vld_p1;
  assign out_pc           = bundle_p1.pc;
  assign cond             = bundle_p1.cond;
  assign opcode           = bundle_p1.opcode;
  assign set_flags        = bundle_p1.set_flags;
  assign rd               = bundle_p1.rd;
  assign rn               = bundle_p1.rn;
  assign rm               = bundle_p1.rm;
  assign rs               = bundle_p1.rs;
  assign shift            = bundle_p1.shift;
  assign shift_amount     = bundle_p1.shift_amount;
  assign use_rs           = bundle_p1.use_rs;
  assign use_imm32        = bundle_p1.use_imm32;
  assign use_register     = bundle_p1.use_register;
  assign rotate_imm       = bundle_p1.rotate_imm;
  assign imm8             = bundle_p1.imm8;
  assign access_memory    = bundle_p1.access_memory;
  assign is_load          = bundle_p1.is_load;
  assign is_unsigned_byte = bundle_p1.is_unsigned_byte;
  assign is_not_postindex = bundle_p1.is_not_postindex;
  assign is_added_offset  = bundle_p1.is_added_offset;
  assign is_write_back    = bundle_p1.is_write_back;
  assign mem_write        = bundle_p1.mem_write;
  assign offset_12        = bundle_p1.offset_12;
  assign is_branch        = bundle_p1.is_branch;
  assign branch_with_link = bundle_p1.branch_with_link;
  assign branch_target    = bundle_p1.branch_target;
  assign is_multiply      = bundle_p1.is_multiply;
  assign accumulate       = bundle_p1.accumulate;
  assign undefined        = bundle_p1.undefined;

endmodule
